// File: rtl/prog_loader_if.sv
// Byte-stream receive side and instruction-memory write side of the program loader.
// The loader uses the slave modport; the link/memory model uses master.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed word stream over a byte
// link, writes it into instruction memory and releases the CPU once the checksum matches.
module prog_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_req,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DATA, WR, CHK, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rx_ready_q, rx_ready_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Datapath registers that need no reset value.
  logic [15:0] n_q, n_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [31:0] asm_q, asm_d;

  logic        accept;
  logic [15:0] n_w;

  assign accept = bus.rx_valid && rx_ready_q;
  assign n_w    = {hdr_q, bus.rx_data};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    n_d     = n_q;
    hdr_d   = hdr_q;
    asm_d   = asm_q;

    if (accept) chk_d = chk_q ^ bus.rx_data;

    case (state_q)
      HDR_HI: if (accept) begin
        hdr_d   = bus.rx_data;
        state_d = HDR_LO;
      end
      HDR_LO: if (accept) begin
        n_d   = n_w;
        idx_d = '0;
        if (n_w == 16'd0)                  state_d = CHK;
        else if ({16'd0, n_w} > MAX_WORDS) state_d = ERR;
        else                               state_d = DATA;
      end
      DATA: if (accept) begin
        asm_d = {asm_q[23:0], bus.rx_data};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Address and word are latched on entry so they are valid for the whole WR cycle.
          state_d = WR;
          addr_d  = ADDR_BASE + {14'd0, idx_q, 2'b00};
          wdata_d = {asm_q[23:0], bus.rx_data};
        end
      end
      WR: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_q + 16'd1 == n_q) ? CHK : DATA;
      end
      CHK: if (accept) begin
        state_d = (bus.rx_data == chk_q) ? DONE : ERR;
      end
      DONE, ERR: if (load_req) begin
        state_d = HDR_HI;
        idx_d   = '0;
        chk_d   = '0;
        cnt_d   = '0;
      end
      default: state_d = HDR_HI;
    endcase

    rx_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                 (state_d == DATA)   || (state_d == CHK);
    we_d       = (state_d == WR);
    hold_d     = (state_d != DONE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HDR_HI;
      idx_q      <= '0;
      cnt_q      <= '0;
      chk_q      <= '0;
      addr_q     <= ADDR_BASE;
      wdata_q    <= '0;
      rx_ready_q <= 1'b1;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    n_q   <= n_d;
    hdr_q <= hdr_d;
    asm_q <= asm_d;
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-built byte streams, write log compared
// against expected addresses/words, status outputs checked after each load.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req = 1'b0;
  logic cpu_hold, done, err;

  prog_loader_if ifc();

  prog_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .bus      (ifc),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stream[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor and always-true output relations.
  always @(negedge clk) begin
    if (rst) begin
      chk("done_err_excl", {31'd0, done & err}, 32'd0);
      if (ifc.imem_we === 1'b1) begin
        wr_addr.push_back(ifc.imem_addr);
        wr_data.push_back(ifc.imem_wdata);
        chk("rdy_in_wr", {31'd0, ifc.rx_ready}, 32'd0);
      end
    end
  end

  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    return x;
  endfunction

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    while (ifc.rx_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream[i]) begin
      if (gaps) begin
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'hA5;
        @(negedge clk);
      end
      send_byte(stream[i]);
    end
    ifc.rx_valid = 1'b0;
  endtask

  task automatic restart();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    stream.delete();
  endtask

  initial begin
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    #3 rst = 1'b0;
    #1;
    chk("rst_rx_ready", {31'd0, ifc.rx_ready}, 32'd1);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_we", {31'd0, ifc.imem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", ifc.imem_addr, 32'h0);
    chk("rst_wdata", ifc.imem_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single-word load with explicit write-latency check.
    stream = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    foreach (stream[i]) begin
      send_byte(stream[i]);
      if (i == 4) chk("we_before_4th", {31'd0, ifc.imem_we}, 32'd0);
      if (i == 5) chk("we_latency", {31'd0, ifc.imem_we}, 32'd1);
    end
    ifc.rx_valid = 1'b0;
    @(negedge clk);
    chk("t1_writes", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t1_addr", wr_addr[0], 32'h0);
      chk("t1_data", wr_data[0], 32'h2008_0005);
    end
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_rdy", {31'd0, ifc.rx_ready}, 32'd0);

    // Bad checksum.
    restart();
    chk("rl_rdy", {31'd0, ifc.rx_ready}, 32'd1);
    chk("rl_hold", {31'd0, cpu_hold}, 32'd1);
    stream = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    send_stream(1'b0);
    repeat (3) @(negedge clk);
    chk("t2_writes", wr_addr.size(), 32'd1);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd0);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t2_rdy", {31'd0, ifc.rx_ready}, 32'd0);

    // Oversize header.
    restart();
    chk("t3_err_clr", {31'd0, err}, 32'd0);
    stream = '{8'h01, 8'h01};
    send_stream(1'b0);
    @(negedge clk);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_writes", wr_addr.size(), 32'd0);

    // Zero-length, good then bad checksum.
    restart();
    stream = '{8'h00, 8'h00, 8'h00};
    send_stream(1'b0);
    @(negedge clk);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_writes", wr_addr.size(), 32'd0);
    restart();
    stream = '{8'h00, 8'h00, 8'hFF};
    send_stream(1'b0);
    @(negedge clk);
    chk("t4b_err", {31'd0, err}, 32'd1);
    chk("t4b_hold", {31'd0, cpu_hold}, 32'd1);

    // Three words with rx_valid gaps.
    restart();
    stream = '{8'h00, 8'h03};
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    push_word(32'h99AA_BBCC);
    stream.push_back(xsum());
    send_stream(1'b1);
    @(negedge clk);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_writes", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      chk("t5_a0", wr_addr[0], 32'h0);
      chk("t5_a1", wr_addr[1], 32'h4);
      chk("t5_a2", wr_addr[2], 32'h8);
      chk("t5_d0", wr_data[0], 32'h1122_3344);
      chk("t5_d1", wr_data[1], 32'h5566_7788);
      chk("t5_d2", wr_data[2], 32'h99AA_BBCC);
    end

    // Abort a 2-word load after byte 3, then a fresh 1-word load.
    restart();
    stream = '{8'h00, 8'h02, 8'hAA};
    send_stream(1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_rdy", {31'd0, ifc.rx_ready}, 32'd1);
    chk("t6_rst_we", {31'd0, ifc.imem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stream.delete();
    stream = '{8'h00, 8'h01};
    push_word(32'hDEAD_BEEF);
    stream.push_back(xsum());
    send_stream(1'b0);
    @(negedge clk);
    chk("t6_writes", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t6_addr", wr_addr[0], 32'h0);
      chk("t6_data", wr_data[0], 32'hDEAD_BEEF);
    end
    chk("t6_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
